// File: rtl/cv32e40s_lsu_buffered_resp_tracker.sv
// In-order tracker for up to DEPTH outstanding LSU/OBI transfers. Bufferable
// transfers are answered early; their bus errors land in a sticky imprecise-error register.
module cv32e40s_lsu_buffered_resp_tracker #(
  parameter int DEPTH         = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int EARLY_RESP_EN = 1,
  parameter int CNT_WIDTH     = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic                  bufferable_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  resp_valid_i,
  input  logic                  resp_err_i,
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  core_cnt_o,
  output logic [CNT_WIDTH-1:0]  bus_cnt_o,
  output logic                  imp_err_valid_o,
  output logic [ADDR_WIDTH-1:0] imp_err_addr_o,
  output logic                  imp_err_store_o,
  output logic                  imp_err_overflow_o,
  input  logic                  imp_err_ack_i,
  output logic                  protocol_err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  store;
    logic                  bufferable;
  } entry_t;

  entry_t               q [DEPTH];
  entry_t               bus_head, core_head;
  logic [PTR_W-1:0]     wr_ptr, bus_rd_ptr, core_rd_ptr;
  logic [CNT_WIDTH-1:0] bus_cnt, core_cnt;
  logic                 has_space, accept, bus_pop, core_pop, head_match, imp_new;

  // Explicit wrap so non-power-of-2 depths stay inside the queue.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign has_space = (bus_cnt < CNT_MAX);
  assign valid_o   = valid_i && has_space;
  assign ready_o   = ready_i && has_space;
  assign accept    = valid_o && ready_i;

  assign bus_head   = q[bus_rd_ptr];
  assign core_head  = q[core_rd_ptr];
  assign bus_pop    = resp_valid_i && (bus_cnt != '0);
  assign head_match = (bus_cnt != '0) && (bus_rd_ptr == core_rd_ptr);

  // A non-bufferable core entry only completes together with its own bus response.
  always_comb begin
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    if (core_cnt != '0) begin
      if (core_head.bufferable) begin
        resp_valid_o = 1'b1;
      end else if (head_match) begin
        resp_valid_o = resp_valid_i;
        resp_err_o   = resp_valid_i && resp_err_i;
      end
    end
  end

  assign core_pop       = resp_valid_o;
  assign imp_new        = bus_pop && bus_head.bufferable && resp_err_i;
  assign protocol_err_o = resp_valid_i && (bus_cnt == '0);
  assign busy_o         = (bus_cnt != '0) || (core_cnt != '0) || valid_i;
  assign core_cnt_o     = core_cnt;
  assign bus_cnt_o      = bus_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      wr_ptr      <= '0;
      bus_rd_ptr  <= '0;
      core_rd_ptr <= '0;
      bus_cnt     <= '0;
      core_cnt    <= '0;
    end else begin
      if (accept) begin
        q[wr_ptr] <= '{addr: addr_i, store: we_i,
                       bufferable: bufferable_i && (EARLY_RESP_EN != 0)};
        wr_ptr    <= ptr_inc(wr_ptr);
      end
      if (bus_pop)  bus_rd_ptr  <= ptr_inc(bus_rd_ptr);
      if (core_pop) core_rd_ptr <= ptr_inc(core_rd_ptr);
      bus_cnt  <= bus_cnt  + CNT_WIDTH'(accept) - CNT_WIDTH'(bus_pop);
      core_cnt <= core_cnt + CNT_WIDTH'(accept) - CNT_WIDTH'(core_pop);
    end
  end

  // An ack in the same cycle as a new error frees the slot for that new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imp_err_valid_o    <= 1'b0;
      imp_err_addr_o     <= '0;
      imp_err_store_o    <= 1'b0;
      imp_err_overflow_o <= 1'b0;
    end else if (imp_new) begin
      if (!imp_err_valid_o || imp_err_ack_i) begin
        imp_err_valid_o    <= 1'b1;
        imp_err_addr_o     <= bus_head.addr;
        imp_err_store_o    <= bus_head.store;
        imp_err_overflow_o <= 1'b0;
      end else begin
        imp_err_overflow_o <= 1'b1;
      end
    end else if (imp_err_ack_i) begin
      imp_err_valid_o    <= 1'b0;
      imp_err_overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cv32e40s_lsu_buffered_resp_tracker.sv
// Directed bench for the buffered response tracker; DEPTH=2 and DEPTH=3 instances share stimulus.
module tb_cv32e40s_lsu_buffered_resp_tracker;

  logic        clk, rst_n;
  logic        valid, we, bufb, ready, rvalid, rerr, ack;
  logic [31:0] addr;

  logic        r2, v2, rv2, re2, busy2, iv2, is2, io2, pe2;
  logic [1:0]  cc2, bc2;
  logic [31:0] ia2;
  logic        r3, v3, rv3, re3, busy3, iv3, is3, io3, pe3;
  logic [1:0]  cc3, bc3;
  logic [31:0] ia3;

  int   checks = 0;
  int   errors = 0;
  int   sel    = 2;
  logic exp_q[$];

  cv32e40s_lsu_buffered_resp_tracker #(.DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .addr_i(addr), .we_i(we),
    .bufferable_i(bufb), .ready_o(r2), .valid_o(v2), .ready_i(ready),
    .resp_valid_i(rvalid), .resp_err_i(rerr), .resp_valid_o(rv2), .resp_err_o(re2),
    .busy_o(busy2), .core_cnt_o(cc2), .bus_cnt_o(bc2), .imp_err_valid_o(iv2),
    .imp_err_addr_o(ia2), .imp_err_store_o(is2), .imp_err_overflow_o(io2),
    .imp_err_ack_i(ack), .protocol_err_o(pe2));

  cv32e40s_lsu_buffered_resp_tracker #(.DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .addr_i(addr), .we_i(we),
    .bufferable_i(bufb), .ready_o(r3), .valid_o(v3), .ready_i(ready),
    .resp_valid_i(rvalid), .resp_err_i(rerr), .resp_valid_o(rv3), .resp_err_o(re3),
    .busy_o(busy3), .core_cnt_o(cc3), .bus_cnt_o(bc3), .imp_err_valid_o(iv3),
    .imp_err_addr_o(ia3), .imp_err_store_o(is3), .imp_err_overflow_o(io3),
    .imp_err_ack_i(ack), .protocol_err_o(pe3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every core response pops the oldest expected resp_err.
  task automatic mon();
    logic rv, re, e;
    rv = (sel == 3) ? rv3 : rv2;
    re = (sel == 3) ? re3 : re2;
    if (rv) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("sb_resp_err", 32'(re), 32'(e));
      end
    end
  endtask

  task automatic cyc();
    #1;
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; valid = 0; addr = '0; we = 0; bufb = 0; ready = 0;
    rvalid = 0; rerr = 0; ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cc", 32'(cc2), 0);   chk("rst_bc", 32'(bc2), 0);
    chk("rst_iv", 32'(iv2), 0);   chk("rst_busy", 32'(busy2), 0);
    chk("rst_v", 32'(v2), 0);     chk("rst_r", 32'(r2), 0);
    chk("rst_rv", 32'(rv2), 0);   chk("rst_pe", 32'(pe2), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // three non-bufferable loads, DEPTH=2 holds off the third
    ready = 1; valid = 1; addr = 32'h100; exp_q.push_back(1'b0);
    #1; chk("t1_v0", 32'(v2), 1); chk("t1_rdy", 32'(r2), 1);
    cyc();
    addr = 32'h104; exp_q.push_back(1'b1);
    #1; chk("t1_v1", 32'(v2), 1);
    cyc();
    addr = 32'h108; exp_q.push_back(1'b0);
    #1; chk("t1_hold", 32'(v2), 0); chk("t1_bc2", 32'(bc2), 2); chk("t1_rdy_hold", 32'(r2), 0);
    cyc();
    rvalid = 1; rerr = 0;
    #1; chk("t1_hold2", 32'(v2), 0); chk("t1_rv_a", 32'(rv2), 1);
    cyc();
    rvalid = 0;
    #1; chk("t1_v2", 32'(v2), 1); chk("t1_rv_b", 32'(rv2), 0);
    cyc();
    valid = 0;
    #1; chk("t1_bc_full", 32'(bc2), 2); chk("t1_rv_c", 32'(rv2), 0);
    cyc();
    rvalid = 1; rerr = 1;
    #1; chk("t1_rv_d", 32'(rv2), 1); chk("t1_re_d", 32'(re2), 1);
    cyc();
    rerr = 0;
    #1; chk("t1_rv_e", 32'(rv2), 1);
    cyc();
    rvalid = 0;
    #1; chk("t1_bc_end", 32'(bc2), 0); chk("t1_cc_end", 32'(cc2), 0); chk("t1_busy", 32'(busy2), 0);

    // bufferable store with bus error -> early response, imprecise capture
    valid = 1; we = 1; bufb = 1; addr = 32'h1000; exp_q.push_back(1'b0);
    cyc();
    valid = 0;
    #1; chk("t2_early", 32'(rv2), 1); chk("t2_re", 32'(re2), 0);
    cyc();
    #1; chk("t2_rv_off", 32'(rv2), 0); chk("t2_cc", 32'(cc2), 0); chk("t2_bc", 32'(bc2), 1);
    rvalid = 1; rerr = 1;
    #1; chk("t2_rv_bus", 32'(rv2), 0); chk("t2_re_bus", 32'(re2), 0);
    cyc();
    rvalid = 0; rerr = 0;
    #1; chk("t2_iv", 32'(iv2), 1); chk("t2_ia", ia2, 32'h1000);
    chk("t2_is", 32'(is2), 1); chk("t2_io", 32'(io2), 0); chk("t2_bc0", 32'(bc2), 0);

    // second imprecise error before ack -> overflow, first capture kept
    valid = 1; addr = 32'h2000; exp_q.push_back(1'b0);
    cyc();
    valid = 0;
    #1; chk("t3_early", 32'(rv2), 1);
    cyc();
    rvalid = 1; rerr = 1;
    cyc();
    rvalid = 0; rerr = 0;
    #1; chk("t3_io", 32'(io2), 1); chk("t3_ia", ia2, 32'h1000); chk("t3_iv", 32'(iv2), 1);
    ack = 1;
    cyc();
    ack = 0;
    #1; chk("t3_ack_iv", 32'(iv2), 0); chk("t3_ack_io", 32'(io2), 0);

    // ack coinciding with a new error captures the new one
    valid = 1; addr = 32'h3000; exp_q.push_back(1'b0);
    cyc();
    valid = 0;
    cyc();
    rvalid = 1; rerr = 1;
    cyc();
    rvalid = 0; rerr = 0;
    valid = 1; addr = 32'h4000; exp_q.push_back(1'b0);
    cyc();
    valid = 0;
    cyc();
    rvalid = 1; rerr = 1; ack = 1;
    cyc();
    rvalid = 0; rerr = 0; ack = 0;
    #1; chk("t3b_iv", 32'(iv2), 1); chk("t3b_ia", ia2, 32'h4000); chk("t3b_io", 32'(io2), 0);
    ack = 1;
    cyc();
    ack = 0;
    #1; chk("t3b_clr", 32'(iv2), 0);

    // bufferable store then non-bufferable load
    valid = 1; we = 1; bufb = 1; addr = 32'h5000; exp_q.push_back(1'b0);
    cyc();
    we = 0; bufb = 0; addr = 32'h6000; exp_q.push_back(1'b1);
    #1; chk("t4_st_early", 32'(rv2), 1);
    cyc();
    valid = 0;
    #1; chk("t4_ld_wait", 32'(rv2), 0);
    cyc();
    rvalid = 1; rerr = 0;
    #1; chk("t4_ld_wait2", 32'(rv2), 0);
    cyc();
    rerr = 1;
    #1; chk("t4_ld_rv", 32'(rv2), 1); chk("t4_ld_re", 32'(re2), 1);
    cyc();
    rvalid = 0; rerr = 0;
    #1; chk("t4_iv", 32'(iv2), 0); chk("t4_bc", 32'(bc2), 0); chk("t4_cc", 32'(cc2), 0);

    // unmatched rvalid
    rvalid = 1;
    #1; chk("t5_pe", 32'(pe2), 1); chk("t5_bc", 32'(bc2), 0);
    cyc();
    rvalid = 0;
    #1; chk("t5_pe_off", 32'(pe2), 0); chk("t5_bc0", 32'(bc2), 0); chk("t5_cc0", 32'(cc2), 0);

    // reset in the middle of an outstanding transfer
    valid = 1; addr = 32'h7000;
    cyc();
    valid = 0;
    #1; chk("t6_pre_bc", 32'(bc2), 1);
    rst_n = 0;
    #1; chk("t6_rst_bc", 32'(bc2), 0); chk("t6_rst_cc", 32'(cc2), 0); chk("t6_rst_busy", 32'(busy2), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // DEPTH=3: continuous accept+response, pointers wrap, mixed bufferable
    sel = 3;
    for (int k = 0; k < 9; k++) begin
      valid = (k < 7);
      addr  = 32'h4000 + 32'(k * 16);
      bufb  = (k == 1 || k == 4);
      we    = bufb;
      if (k < 7) exp_q.push_back(bufb ? 1'b0 : (k == 3 || k == 5));
      rvalid = (k >= 2);
      rerr   = (k - 2 == 3 || k - 2 == 4 || k - 2 == 5);
      #1;
      if (k >= 3 && k <= 6) begin
        chk("t7_bc", 32'(bc3), 2); chk("t7_cc", 32'(cc3), 2);
      end
      if (k < 7) chk("t7_v", 32'(v3), 1);
      chk("t7_pe", 32'(pe3), 0);
      cyc();
    end
    valid = 0; rvalid = 0; rerr = 0; bufb = 0; we = 0;
    #1; chk("t7_bc0", 32'(bc3), 0); chk("t7_cc0", 32'(cc3), 0);
    chk("t7_iv", 32'(iv3), 1); chk("t7_ia", ia3, 32'h4040);
    chk("t7_is", 32'(is3), 1); chk("t7_io", 32'(io3), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
